// File: rtl/seg_scan_driver_if.sv
// Bundles the scan-mux-facing inputs and the pad-facing outputs of the 7-seg output stage.
// The master modport belongs to whatever drives the scan mux side; the slave modport is the driver itself.
interface seg_scan_driver_if #(
    parameter int NDIG     = 10,
    parameter int NSEG     = 8,
    parameter int PWM_BITS = 4
);
    logic                enable;
    logic [NDIG-1:0]     sel_in;
    logic [NSEG-1:0]     segm_in;
    logic [PWM_BITS-1:0] brightness;
    logic [NDIG-1:0]     sel_out;
    logic [NSEG-1:0]     segm_out;
    logic                blanking;
    logic                err_onehot;

    modport master (
        output enable, sel_in, segm_in, brightness,
        input  sel_out, segm_out, blanking, err_onehot
    );

    modport slave (
        input  enable, sel_in, segm_in, brightness,
        output sel_out, segm_out, blanking, err_onehot
    );
endinterface

// File: rtl/seg_scan_driver.sv
// 7-seg pad output stage: anti-ghosting blank on every digit change, PWM brightness on the
// segments, pad polarity, and flagging of malformed (non-one-hot) digit selects.
// Every output is a register loaded from next-state values, so pads never see combinational glitches.
module seg_scan_driver #(
    parameter int NDIG           = 10,
    parameter int NSEG           = 8,
    parameter int BLANK_CYC      = 4,
    parameter int PWM_BITS       = 4,
    parameter bit SEL_ACTIVE_LOW = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input logic              clk,
    input logic              rst,
    seg_scan_driver_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BLANK = 2'd1;
    localparam logic [1:0] S_DRIVE = 2'd2;

    localparam logic [7:0]          BLANK_LOAD = 8'(BLANK_CYC - 1);
    localparam logic [PWM_BITS-1:0] PWM_FULL   = {PWM_BITS{1'b1}};
    localparam logic [NDIG-1:0]     SEL_OFF    = SEL_ACTIVE_LOW ? {NDIG{1'b1}} : {NDIG{1'b0}};
    localparam logic [NSEG-1:0]     SEG_OFF    = SEG_ACTIVE_LOW ? {NSEG{1'b1}} : {NSEG{1'b0}};

    logic [1:0]          r_state;
    logic [7:0]          r_blank_cnt;
    logic [NDIG-1:0]     r_sel_lat;
    logic [NSEG-1:0]     r_seg_lat;
    logic [PWM_BITS-1:0] r_bright_lat;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [NDIG-1:0]     r_sel_out;
    logic [NSEG-1:0]     r_segm_out;
    logic                r_blanking;
    logic                r_err_onehot;

    logic [1:0]          w_state_next;
    logic [7:0]          w_blank_cnt_next;
    logic [NDIG-1:0]     w_sel_lat_next;
    logic [PWM_BITS-1:0] w_bright_next;
    logic [PWM_BITS-1:0] w_pwm_next;
    logic                w_onehot;
    logic                w_valid;
    logic                w_sel_changed;
    logic                w_pwm_on;
    logic [NSEG-1:0]     w_seg_lit;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
    assign w_onehot      = (bus.sel_in != '0) && ((bus.sel_in & (bus.sel_in - NDIG'(1))) == '0);
    assign w_valid       = bus.enable & w_onehot;
    assign w_sel_changed = (bus.sel_in != r_sel_lat);

    // Next-state logic: any invalid input drops to IDLE; any digit change restarts a full blank.
    always_comb begin
        w_state_next     = r_state;
        w_blank_cnt_next = r_blank_cnt;
        w_sel_lat_next   = r_sel_lat;
        w_bright_next    = r_bright_lat;
        w_pwm_next       = r_pwm_cnt;
        if (!w_valid) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_next     = S_BLANK;
                    w_blank_cnt_next = BLANK_LOAD;
                    w_sel_lat_next   = bus.sel_in;
                end
                S_BLANK: begin
                    if (w_sel_changed) begin
                        w_blank_cnt_next = BLANK_LOAD;
                        w_sel_lat_next   = bus.sel_in;
                    end else if (r_blank_cnt == 8'd0) begin
                        w_state_next  = S_DRIVE;
                        w_bright_next = bus.brightness;
                        w_pwm_next    = '0;
                    end else begin
                        w_blank_cnt_next = r_blank_cnt - 8'd1;
                    end
                end
                S_DRIVE: begin
                    if (w_sel_changed) begin
                        w_state_next     = S_BLANK;
                        w_blank_cnt_next = BLANK_LOAD;
                        w_sel_lat_next   = bus.sel_in;
                    end else begin
                        w_pwm_next = r_pwm_cnt + PWM_BITS'(1);
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // All-ones brightness means always on; otherwise the first bright_lat slots of the period are lit.
    assign w_pwm_on  = (w_bright_next == PWM_FULL) || (w_pwm_next < w_bright_next);
    assign w_seg_lit = ((w_state_next == S_DRIVE) && w_pwm_on) ? r_seg_lat : '0;

    // Control state, latches and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_blank_cnt  <= '0;
            r_sel_lat    <= '0;
            r_seg_lat    <= '0;
            r_bright_lat <= '0;
            r_pwm_cnt    <= '0;
        end else begin
            r_state      <= w_state_next;
            r_blank_cnt  <= w_blank_cnt_next;
            r_sel_lat    <= w_sel_lat_next;
            r_seg_lat    <= bus.segm_in;
            r_bright_lat <= w_bright_next;
            r_pwm_cnt    <= w_pwm_next;
        end
    end

    // Pad-facing output registers with polarity applied; inactive outside DRIVE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel_out    <= SEL_OFF;
            r_segm_out   <= SEG_OFF;
            r_blanking   <= 1'b0;
            r_err_onehot <= 1'b0;
        end else begin
            r_sel_out    <= (w_state_next == S_DRIVE) ? (SEL_ACTIVE_LOW ? ~r_sel_lat : r_sel_lat) : SEL_OFF;
            r_segm_out   <= SEG_ACTIVE_LOW ? ~w_seg_lit : w_seg_lit;
            r_blanking   <= (w_state_next == S_BLANK);
            r_err_onehot <= bus.enable & ~w_onehot;
        end
    end

    assign bus.sel_out    = r_sel_out;
    assign bus.segm_out   = r_segm_out;
    assign bus.blanking   = r_blanking;
    assign bus.err_onehot = r_err_onehot;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: directed scenarios plus randomized digit/segment
// traffic compared each clock against a reference model that tracks how long the current
// digit has been steadily selected.
module tb_seg_scan_driver;
    localparam int NDIG      = 10;
    localparam int NSEG      = 8;
    localparam int BLANK_CYC = 4;
    localparam int PWM_BITS  = 4;
    localparam int PERIOD    = 1 << PWM_BITS;

    logic clk;
    logic rst;
    int   n_total = 0;
    int   n_bad   = 0;

    seg_scan_driver_if #(.NDIG(NDIG), .NSEG(NSEG), .PWM_BITS(PWM_BITS)) bus ();

    seg_scan_driver #(
        .NDIG(NDIG), .NSEG(NSEG), .BLANK_CYC(BLANK_CYC), .PWM_BITS(PWM_BITS),
        .SEL_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state: age = number of consecutive valid edges on the same digit.
    int              m_age;
    bit              m_valid_prev;
    logic [NDIG-1:0] m_digit;
    logic [NSEG-1:0] m_prev_seg;
    int              m_bright;
    logic [NDIG-1:0] exp_sel;
    logic [NSEG-1:0] exp_seg;
    logic            exp_blank;
    logic            exp_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_age        = 0;
        m_valid_prev = 1'b0;
        m_digit      = '0;
        m_prev_seg   = '0;
        m_bright     = 0;
        exp_sel      = '1;
        exp_seg      = '0;
        exp_blank    = 1'b0;
        exp_err      = 1'b0;
    endtask

    // Applied at each rising edge using the inputs held across that edge.
    task automatic model_edge();
        int  ones;
        bit  valid;
        int  phase;
        bit  lit;
        ones    = $countones(bus.sel_in);
        valid   = bus.enable && (ones == 1);
        exp_err = bus.enable && (ones != 1);
        if (!valid) m_age = 0;
        else if (!m_valid_prev || bus.sel_in != m_digit) begin
            m_digit = bus.sel_in;
            m_age   = 1;
        end else m_age++;
        m_valid_prev = valid;
        exp_sel   = '1;
        exp_seg   = '0;
        exp_blank = 1'b0;
        if (m_age >= 1 && m_age <= BLANK_CYC) exp_blank = 1'b1;
        else if (m_age > BLANK_CYC) begin
            if (m_age == BLANK_CYC + 1) m_bright = int'(bus.brightness);
            phase   = (m_age - BLANK_CYC - 1) % PERIOD;
            lit     = (m_bright == PERIOD - 1) || (phase < m_bright);
            exp_sel = ~m_digit;
            exp_seg = lit ? m_prev_seg : '0;
        end
        m_prev_seg = bus.segm_in;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("sel_out",    32'(bus.sel_out),    32'(exp_sel));
        chk("segm_out",   32'(bus.segm_out),   32'(exp_seg));
        chk("blanking",   32'(bus.blanking),   32'(exp_blank));
        chk("err_onehot", 32'(bus.err_onehot), 32'(exp_err));
        chk("one_digit",  32'($countones(~bus.sel_out) <= 1), 32'd1);
        $display("cyc en=%b sel=%h seg=%h br=%h -> sel_out=%h segm_out=%h blk=%b err=%b",
                 bus.enable, bus.sel_in, bus.segm_in, bus.brightness,
                 bus.sel_out, bus.segm_out, bus.blanking, bus.err_onehot);
    endtask

    task automatic set_in(input logic en, input logic [NDIG-1:0] sel,
                          input logic [NSEG-1:0] seg, input logic [PWM_BITS-1:0] br);
        bus.enable     = en;
        bus.sel_in     = sel;
        bus.segm_in    = seg;
        bus.brightness = br;
    endtask

    initial begin
        logic [NDIG-1:0] rsel;
        int              dur;
        int              kind;
        model_reset();
        // Reset asserted from time zero with arbitrary inputs; checked before any clock edge.
        rst = 1'b1;
        set_in(1'b1, 10'h003, 8'hA5, 4'h7);
        #2;
        chk("rst_sel",   32'(bus.sel_out),    32'h3FF);
        chk("rst_seg",   32'(bus.segm_out),   32'h00);
        chk("rst_blank", 32'(bus.blanking),   32'h0);
        chk("rst_err",   32'(bus.err_onehot), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // First digit: four blank clocks then steady full-brightness drive.
        set_in(1'b1, 10'h001, 8'hCE, 4'hF);
        for (int i = 0; i < BLANK_CYC; i++) begin
            tick();
            chk("t2_blank", 32'(bus.blanking), 32'h1);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("t2_sel", 32'(bus.sel_out),  32'h3FE);
            chk("t2_seg", 32'(bus.segm_out), 32'hCE);
        end

        // Digit change with brightness 4: exact blank window, then 4-of-16 PWM.
        set_in(1'b1, 10'h002, 8'hCE, 4'h4);
        for (int i = 0; i < BLANK_CYC; i++) begin
            tick();
            chk("t4_dark", 32'(bus.sel_out), 32'h3FF);
        end
        for (int i = 0; i < 2 * PERIOD; i++) begin
            tick();
            chk("t3_sel", 32'(bus.sel_out), 32'h3FD);
            chk("t3_seg", 32'(bus.segm_out), (i % PERIOD < 4) ? 32'hCE : 32'h00);
        end

        // Malformed selects, then recovery through a full blank.
        set_in(1'b1, 10'h003, 8'hCE, 4'hF);
        tick();
        chk("t5_err_two", 32'(bus.err_onehot), 32'h1);
        bus.sel_in = 10'h000;
        tick();
        chk("t5_err_zero", 32'(bus.err_onehot), 32'h1);
        chk("t5_dark",     32'(bus.sel_out),    32'h3FF);
        bus.sel_in = 10'h004;
        for (int i = 0; i < BLANK_CYC; i++) begin
            tick();
            chk("t5_blank", 32'(bus.blanking), 32'h1);
        end
        tick();
        chk("t5_sel", 32'(bus.sel_out),    32'h3FB);
        chk("t5_err", 32'(bus.err_onehot), 32'h0);
        for (int i = 0; i < 6; i++) tick();

        // Reset pulse between edges while driving; inputs stay valid across release.
        @(posedge clk);
        model_edge();
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        chk("t6_sel", 32'(bus.sel_out),  32'h3FF);
        chk("t6_seg", 32'(bus.segm_out), 32'h00);
        #2;
        rst = 1'b0;
        for (int i = 0; i < BLANK_CYC; i++) begin
            tick();
            chk("t6_blank", 32'(bus.blanking), 32'h1);
        end
        tick();
        chk("t6_sel_back", 32'(bus.sel_out), 32'h3FB);

        // Randomized traffic: held digits of random length, glitchy selects, enable drops.
        for (int s = 0; s < 120; s++) begin
            kind = $urandom_range(0, 9);
            rsel = '0;
            if (kind <= 5)      rsel[$urandom_range(0, NDIG - 1)] = 1'b1;
            else if (kind == 6) rsel = '0;
            else if (kind == 7) rsel = NDIG'($urandom) | NDIG'(10'h201);
            else                rsel = bus.sel_in;
            bus.enable     = ($urandom_range(0, 15) != 0);
            bus.sel_in     = rsel;
            bus.brightness = PWM_BITS'($urandom);
            dur = $urandom_range(1, 40);
            for (int c = 0; c < dur; c++) begin
                if ($urandom_range(0, 3) == 0) bus.segm_in = NSEG'($urandom);
                if ($urandom_range(0, 7) == 0) bus.brightness = PWM_BITS'($urandom);
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
